// File: rtl/sign_extender_pipe.sv
// LEGv8 immediate extractor/extender (I, D, B, CB, IW formats) registered behind
// a 2-entry elastic buffer (main + skid) with valid/ready on both sides.
module sign_extender_pipe #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned BR_SHIFT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [25:0]       Imm26,
  input  logic [2:0]        Ctrl,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] BusImm,
  output logic              Illegal
);

  localparam int unsigned BR_SH = (BR_SHIFT != 0) ? 2 : 0;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } buf_state_t;

  buf_state_t        r_state;
  buf_state_t        w_state_nxt;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_imm;
  logic              r_main_ill;
  logic [DATA_W-1:0] r_skid_imm;
  logic              r_skid_ill;

  logic [DATA_W-1:0] w_imm;
  logic              w_ill;
  logic [1:0]        w_hw;
  logic              w_accept;
  logic              w_pop;
  logic              w_load_main;
  logic              w_load_skid;
  logic              w_main_from_skid;

  assign w_hw = Imm26[22:21];

  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (Ctrl)
      3'b000: w_imm = {{(DATA_W-12){1'b0}}, Imm26[21:10]};
      3'b001: w_imm = {{(DATA_W-9){Imm26[20]}}, Imm26[20:12]};
      3'b010: w_imm = {{(DATA_W-26){Imm26[25]}}, Imm26[25:0]} << BR_SH;
      3'b011: w_imm = {{(DATA_W-19){Imm26[23]}}, Imm26[23:5]} << BR_SH;
      3'b100: begin
        // A halfword slot that does not fit in DATA_W is flagged, not wrapped.
        if ((32'(w_hw) + 32'd1) * 32'd16 > DATA_W) begin
          w_ill = 1'b1;
        end else begin
          w_imm = {{(DATA_W-16){1'b0}}, Imm26[20:5]} << {w_hw, 4'b0000};
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign OutValid = (r_state != S_EMPTY);
  assign InReady  = r_in_ready;
  assign BusImm   = r_main_imm;
  assign Illegal  = r_main_ill;
  assign w_accept = InValid & r_in_ready;
  assign w_pop    = OutValid & OutReady;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt      = S_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // InReady is the registered "skid not full" of the next state, so it never
  // depends combinationally on OutReady.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_main_imm <= '0;
      r_main_ill <= 1'b0;
      r_skid_imm <= '0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_imm <= w_imm;
        r_main_ill <= w_ill;
      end else if (w_main_from_skid) begin
        r_main_imm <= r_skid_imm;
        r_main_ill <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_imm;
        r_skid_ill <= w_ill;
      end
    end
  end

endmodule
